cache_wb_engine: RTL and testbench

//  Dirty-line writeback engine for the custom_cpu cache. Takes a victim (index, tag) from the cache FSM,

---
 rtl/cache_wb_engine_pkg.sv | 27 ++
 rtl/cache_wb_engine_if.sv | 40 ++++
 rtl/cache_wb_engine_line_buf.sv | 29 ++
 rtl/cache_wb_engine.sv | 75 +++++++
 tb/tb_cache_wb_engine.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cache_wb_engine_pkg.sv
// Shared constants for the cache writeback path: line/word geometry,
// address split, FSM state encodings and the line-address helper.
package cache_wb_engine_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int WORD_WIDTH  = 32;
  localparam int INDEX_WIDTH = 3;
  localparam int TAG_WIDTH   = 24;
  localparam int BEATS       = LINE_WIDTH / WORD_WIDTH;
  localparam int BEAT_W      = $clog2(BEATS);
  localparam int OFFSET_W    = $clog2(LINE_WIDTH / 8);
  localparam int STRB_W      = WORD_WIDTH / 8;

  // Encodings are shared with the data array and refill engine; keep as plain constants.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_AW   = 3'd2;
  localparam logic [2:0] ST_W    = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Line-aligned byte address of a (tag, index) pair.
  function automatic logic [31:0] line_addr(input logic [TAG_WIDTH-1:0]   tag,
                                            input logic [INDEX_WIDTH-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_wb_engine_if.sv
// Writeback engine bus bundle: victim request from the cache FSM, the
// data-array combinational read port, and the memory write burst channel.
//   master : engine side (drives ready/raddr/mem_wr_*/wb_done)
//   slave  : environment side (cache FSM, data array, memory)
interface cache_wb_engine_if;
  import cache_wb_engine_pkg::*;

  logic                   wb_req_valid;
  logic                   wb_req_ready;
  logic [INDEX_WIDTH-1:0] wb_index;
  logic [TAG_WIDTH-1:0]   wb_tag;

  logic [INDEX_WIDTH-1:0] arr_raddr;
  logic [LINE_WIDTH-1:0]  arr_rdata;

  logic                   mem_wr_req_valid;
  logic                   mem_wr_req_ready;
  logic [31:0]            mem_wr_addr;
  logic [7:0]             mem_wr_len;
  logic                   mem_wr_data_valid;
  logic                   mem_wr_data_ready;
  logic [WORD_WIDTH-1:0]  mem_wr_data;
  logic [STRB_W-1:0]      mem_wr_strb;
  logic                   mem_wr_last;

  logic                   wb_done;

  modport master (
    input  wb_req_valid, wb_index, wb_tag, arr_rdata, mem_wr_req_ready, mem_wr_data_ready,
    output wb_req_ready, arr_raddr, mem_wr_req_valid, mem_wr_addr, mem_wr_len,
           mem_wr_data_valid, mem_wr_data, mem_wr_strb, mem_wr_last, wb_done
  );

  modport slave (
    output wb_req_valid, wb_index, wb_tag, arr_rdata, mem_wr_req_ready, mem_wr_data_ready,
    input  wb_req_ready, arr_raddr, mem_wr_req_valid, mem_wr_addr, mem_wr_len,
           mem_wr_data_valid, mem_wr_data, mem_wr_strb, mem_wr_last, wb_done
  );

endinterface

// File: rtl/cache_wb_engine_line_buf.sv
// wb_line_buf: holds one cache line; loads the full line in parallel and
// shifts it out one word at a time, lowest word first.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din (takes priority over shift)
//   shift    : drop the low word, move the rest down
//   din      : full line in
//   dout     : current low word
module wb_line_buf
  import cache_wb_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [LINE_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout
);

  logic [LINE_WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= q >> WORD_WIDTH;
  end

  assign dout = q[WORD_WIDTH-1:0];

endmodule

// File: rtl/cache_wb_engine.sv
// cache_wb_engine: dirty-line writeback. Accepts a victim (index, tag),
// snapshots the line from the data array in one READ cycle, issues one
// address request, then streams BEATS words and pulses wb_done.
//   clk, rst : clock, synchronous active-high reset (abandons any burst)
//   bus      : cache_wb_engine_if.master (request, array read port, memory write)
module cache_wb_engine
  import cache_wb_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_wb_engine_if.master  bus
);

  logic [2:0]             state;
  logic [INDEX_WIDTH-1:0] index_reg;
  logic [TAG_WIDTH-1:0]   tag_reg;
  logic [BEAT_W-1:0]      beat;

  logic req_fire, aw_fire, w_fire, last_beat;

  assign req_fire  = (state == ST_IDLE) && bus.wb_req_valid;
  assign aw_fire   = (state == ST_AW)   && bus.mem_wr_req_ready;
  assign w_fire    = (state == ST_W)    && bus.mem_wr_data_ready;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      index_reg <= '0;
      tag_reg   <= '0;
      beat      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_fire) begin
          index_reg <= bus.wb_index;
          tag_reg   <= bus.wb_tag;
          state     <= ST_READ;
        end
        ST_READ: state <= ST_AW;
        ST_AW: if (aw_fire) begin
          beat  <= '0;
          state <= ST_W;
        end
        ST_W: if (w_fire) begin
          // W exits on the last beat, so the counter never needs to wrap.
          if (last_beat) state <= ST_DONE;
          else           beat  <= beat + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot is taken at the end of READ; later array writes cannot reach the burst.
  wb_line_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (state == ST_READ),
    .shift (w_fire),
    .din   (bus.arr_rdata),
    .dout  (bus.mem_wr_data)
  );

  assign bus.wb_req_ready      = (state == ST_IDLE);
  assign bus.arr_raddr         = (state == ST_READ) ? index_reg : '0;
  assign bus.mem_wr_req_valid  = (state == ST_AW);
  assign bus.mem_wr_addr       = line_addr(tag_reg, index_reg);
  assign bus.mem_wr_len        = 8'(BEATS - 1);
  assign bus.mem_wr_data_valid = (state == ST_W);
  assign bus.mem_wr_strb       = '1;
  assign bus.mem_wr_last       = (state == ST_W) && last_beat;
  assign bus.wb_done           = (state == ST_DONE);

endmodule

// File: tb/tb_cache_wb_engine.sv
module tb_cache_wb_engine;
  import cache_wb_engine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_wb_engine_if bus ();

  cache_wb_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data array model: 8 lines, combinational read.
  logic [LINE_WIDTH-1:0] arr [8];
  assign bus.arr_rdata = arr[bus.arr_raddr];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.wb_req_ready), 64'd1);
    chk({tag, "_aw_valid"},  64'(bus.mem_wr_req_valid), 64'd0);
    chk({tag, "_w_valid"},   64'(bus.mem_wr_data_valid), 64'd0);
    chk({tag, "_last"},      64'(bus.mem_wr_last), 64'd0);
    chk({tag, "_done"},      64'(bus.wb_done), 64'd0);
    chk({tag, "_raddr"},     64'(bus.arr_raddr), 64'd0);
  endtask

  // One writeback, driven and checked cycle by cycle at negedge.
  // dmode: 0 data_ready always 1, 1 toggles 1010.., 2 random.
  task automatic do_txn(input logic [INDEX_WIDTH-1:0] idx, input logic [TAG_WIDTH-1:0] tag,
                        input int aw_stall, input int dmode, input bit snap_write,
                        input int abort_at, input bit busy_poke);
    logic [LINE_WIDTH-1:0] exp_line;
    logic [31:0]           exp_addr;
    int beat, cyc, w_stalls, guard;
    bit rdy;
    exp_line = arr[idx];
    exp_addr = (32'(tag) << 8) | (32'(idx) << 5);
    chk("accept_ready", 64'(bus.wb_req_ready), 64'd1);
    bus.wb_req_valid = 1'b1;
    bus.wb_index     = idx;
    bus.wb_tag       = tag;
    @(negedge clk);
    cyc = 1;
    bus.wb_req_valid = 1'b0;
    // READ cycle: ready signals high here must be ignored.
    chk("read_raddr",     64'(bus.arr_raddr), 64'(idx));
    chk("read_req_ready", 64'(bus.wb_req_ready), 64'd0);
    chk("read_aw_valid",  64'(bus.mem_wr_req_valid), 64'd0);
    bus.mem_wr_req_ready  = 1'b1;
    bus.mem_wr_data_ready = 1'b1;
    @(negedge clk);
    cyc++;
    for (int c = 0; c <= aw_stall; c++) begin
      chk("aw_valid", 64'(bus.mem_wr_req_valid), 64'd1);
      chk("aw_addr",  64'(bus.mem_wr_addr), 64'(exp_addr));
      chk("aw_len",   64'(bus.mem_wr_len), 64'(BEATS - 1));
      chk("aw_no_w",  64'(bus.mem_wr_data_valid), 64'd0);
      if (snap_write && c == 0) arr[idx] = '1;
      bus.mem_wr_req_ready = (c == aw_stall);
      @(negedge clk);
      cyc++;
    end
    bus.mem_wr_req_ready = 1'b0;
    beat = 0; w_stalls = 0; guard = 0;
    while (beat < BEATS && guard < 200) begin
      chk("w_valid",    64'(bus.mem_wr_data_valid), 64'd1);
      chk("w_data",     64'(bus.mem_wr_data), 64'(exp_line[beat*WORD_WIDTH +: WORD_WIDTH]));
      chk("w_last",     64'(bus.mem_wr_last), 64'(beat == BEATS - 1));
      chk("w_strb",     64'(bus.mem_wr_strb), 64'hF);
      chk("w_aw_idle",  64'(bus.mem_wr_req_valid), 64'd0);
      chk("w_no_done",  64'(bus.wb_done), 64'd0);
      if (busy_poke) chk("w_busy_ready", 64'(bus.wb_req_ready), 64'd0);
      if (beat == abort_at) begin
        rst = 1'b1;
        bus.wb_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort");
        @(negedge clk);
        chk("abort_no_done", 64'(bus.wb_done), 64'd0);
        chk("abort_idle",    64'(bus.wb_req_ready), 64'd1);
        return;
      end
      case (dmode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.mem_wr_data_ready = rdy;
      bus.wb_req_valid = busy_poke && (beat < BEATS - 1);
      bus.wb_index     = ~idx;
      if (rdy) beat++;
      else     w_stalls++;
      guard++;
      @(negedge clk);
      cyc++;
    end
    bus.wb_req_valid      = 1'b0;
    bus.mem_wr_data_ready = 1'b0;
    if (guard >= 200) begin
      chk("w_timeout", 64'd0, 64'd1);
      return;
    end
    chk("done_pulse",   64'(bus.wb_done), 64'd1);
    chk("done_latency", 64'(cyc), 64'(11 + aw_stall + w_stalls));
    chk("done_ready",   64'(bus.wb_req_ready), 64'd0);
    chk("done_no_w",    64'(bus.mem_wr_data_valid), 64'd0);
    @(negedge clk);
    chk_idle("post");
  endtask

  initial begin
    logic [LINE_WIDTH-1:0] line;
    for (int i = 0; i < 8; i++) arr[i] = '0;
    bus.wb_req_valid      = 1'b0;
    bus.wb_index          = '0;
    bus.wb_tag            = '0;
    bus.mem_wr_req_ready  = 1'b0;
    bus.mem_wr_data_ready = 1'b0;

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Happy path: words 0..7 at index 3, zero-stall memory.
    for (int w = 0; w < BEATS; w++) line[w*WORD_WIDTH +: WORD_WIDTH] = 32'(w);
    arr[3] = line;
    chk("addr_const", 64'((32'h00ABCDEF << 8) | (32'd3 << 5)), 64'hABCDEF60);
    do_txn(3'd3, 24'hABCDEF, 0, 0, 1'b0, -1, 1'b0);

    // Address-channel stall for 5 cycles.
    do_txn(3'd3, 24'h123456, 5, 0, 1'b0, -1, 1'b0);

    // Data backpressure 1010..
    arr[5] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_txn(3'd5, 24'h00BEEF, 1, 1, 1'b0, -1, 1'b0);

    // Snapshot: array overwritten during AW; burst keeps the pre-write words.
    arr[3] = line;
    do_txn(3'd3, 24'hABCDEF, 2, 0, 1'b1, -1, 1'b0);

    // Request during W is ignored; then reset at beat 4, then a clean request.
    arr[6] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_txn(3'd6, 24'h0F0F0F, 0, 0, 1'b0, -1, 1'b1);
    do_txn(3'd6, 24'h777777, 0, 0, 1'b0, 4, 1'b0);
    do_txn(3'd6, 24'h777777, 0, 0, 1'b0, -1, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 8; n++) begin
      logic [INDEX_WIDTH-1:0] ri;
      ri = INDEX_WIDTH'($urandom_range(0, 7));
      arr[ri] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_txn(ri, TAG_WIDTH'($urandom), $urandom_range(0, 3), 2, 1'($urandom_range(0, 1)), -1,
             1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
